// File: rtl/build_id_blinker_if.sv
// Control, build-ID word and LED signal bundle between top-level logic and build_id_blinker.
// master drives requests, words and normal LED patterns; slave returns the LED drive and status.
interface build_id_blinker_if;
   logic        start_i;
   logic        abort_i;
   logic [63:0] git_hash_scripts_i;
   logic [31:0] timestamp_scripts_i;
   logic [63:0] git_hash_top_i;
   logic [31:0] timestamp_top_i;
   logic [63:0] git_hash_common_i;
   logic [31:0] timestamp_common_i;
   logic [2:0]  led_0_i;
   logic [2:0]  led_1_i;
   logic [2:0]  led_0_o;
   logic [2:0]  led_1_o;
   logic        busy_o;
   logic        done_o;

   modport master (
      output start_i, abort_i,
      output git_hash_scripts_i, timestamp_scripts_i,
      output git_hash_top_i, timestamp_top_i,
      output git_hash_common_i, timestamp_common_i,
      output led_0_i, led_1_i,
      input  led_0_o, led_1_o, busy_o, done_o
   );

   modport slave (
      input  start_i, abort_i,
      input  git_hash_scripts_i, timestamp_scripts_i,
      input  git_hash_top_i, timestamp_top_i,
      input  git_hash_common_i, timestamp_common_i,
      input  led_0_i, led_1_i,
      output led_0_o, led_1_o, busy_o, done_o
   );
endinterface

// File: rtl/build_id_blinker.sv
// Blinks the six build-ID words nibble by nibble on two 3-bit LED groups;
// passes the normal LED pattern through when idle.
module build_id_blinker #(
   parameter int unsigned TICK_DIV = 25_000_000
) (
   input  logic               clk100,
   input  logic               rstn,
   build_id_blinker_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, MARK, SHOW, GAP} state_t;

   localparam int unsigned    PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]  PRESC_MAX = PW'(TICK_DIV - 1);

   state_t        state_q, state_d;
   logic [2:0]    word_q, word_d;
   logic [3:0]    nib_q, nib_d;
   logic          half_q, half_d;
   logic [PW-1:0] presc_q, presc_d;

   logic [63:0]   ghs_q, ghs_d;
   logic [31:0]   tss_q, tss_d;
   logic [63:0]   ght_q, ght_d;
   logic [31:0]   tst_q, tst_d;
   logic [63:0]   ghc_q, ghc_d;
   logic [31:0]   tsc_q, tsc_d;

   logic [2:0]    led0_q, led0_d;
   logic [2:0]    led1_q, led1_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic          tick;
   logic          capture;
   logic [63:0]   cur_word;
   logic [3:0]    cur_nib;

   always_comb begin
      tick = (state_q != IDLE) && (presc_q == PRESC_MAX);
   end

   // State and datapath registers
   always_ff @(posedge clk100 or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         word_q  <= '0;
         nib_q   <= '0;
         half_q  <= 1'b0;
         presc_q <= '0;
         ghs_q   <= '0;
         tss_q   <= '0;
         ght_q   <= '0;
         tst_q   <= '0;
         ghc_q   <= '0;
         tsc_q   <= '0;
         led0_q  <= '0;
         led1_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         nib_q   <= nib_d;
         half_q  <= half_d;
         presc_q <= presc_d;
         ghs_q   <= ghs_d;
         tss_q   <= tss_d;
         ght_q   <= ght_d;
         tst_q   <= tst_d;
         ghc_q   <= ghc_d;
         tsc_q   <= tsc_d;
         led0_q  <= led0_d;
         led1_q  <= led1_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic; SHOW spans two ticks, tracked by half_q
   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      nib_d   = nib_q;
      half_d  = half_q;
      capture = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start_i && !bus.abort_i) begin
               capture = 1'b1;
               word_d  = 3'd1;
               state_d = MARK;
            end
         end
         MARK: begin
            if (tick) begin
               state_d = SHOW;
               nib_d   = word_q[0] ? 4'd15 : 4'd7;
               half_d  = 1'b0;
            end
         end
         SHOW: begin
            if (tick) begin
               if (!half_q) begin
                  half_d = 1'b1;
               end else begin
                  state_d = GAP;
               end
            end
         end
         GAP: begin
            if (tick) begin
               if (nib_q != 4'd0) begin
                  nib_d   = nib_q - 4'd1;
                  half_d  = 1'b0;
                  state_d = SHOW;
               end else if (word_q < 3'd6) begin
                  word_d  = word_q + 3'd1;
                  state_d = MARK;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_q != IDLE) && bus.abort_i) begin
         state_d = IDLE;
      end
   end

   always_comb begin
      presc_d = '0;
      if ((state_q != IDLE) && (state_d != IDLE) && !tick) begin
         presc_d = presc_q + 1'b1;
      end

      ghs_d = capture ? bus.git_hash_scripts_i  : ghs_q;
      tss_d = capture ? bus.timestamp_scripts_i : tss_q;
      ght_d = capture ? bus.git_hash_top_i      : ght_q;
      tst_d = capture ? bus.timestamp_top_i     : tst_q;
      ghc_d = capture ? bus.git_hash_common_i   : ghc_q;
      tsc_d = capture ? bus.timestamp_common_i  : tsc_q;
   end

   // Outputs are registered from the next state so LEDs change on the same edge as the state
   always_comb begin
      case (word_d)
         3'd1:    cur_word = ghs_q;
         3'd2:    cur_word = {32'd0, tss_q};
         3'd3:    cur_word = ght_q;
         3'd4:    cur_word = {32'd0, tst_q};
         3'd5:    cur_word = ghc_q;
         3'd6:    cur_word = {32'd0, tsc_q};
         default: cur_word = '0;
      endcase
      cur_nib = 4'(cur_word >> {nib_d, 2'b00});

      led0_d = bus.led_0_i;
      led1_d = bus.led_1_i;
      busy_d = 1'b0;
      done_d = 1'b0;

      case (state_d)
         MARK: begin
            led0_d = 3'b111;
            led1_d = word_d;
            busy_d = 1'b1;
         end
         SHOW: begin
            led0_d = cur_nib[2:0];
            led1_d = {2'b00, cur_nib[3]};
            busy_d = 1'b1;
         end
         GAP: begin
            led0_d = '0;
            led1_d = '0;
            busy_d = 1'b1;
         end
         default: begin
            done_d = (state_q == GAP) && !bus.abort_i;
         end
      endcase
   end

   assign bus.led_0_o = led0_q;
   assign bus.led_1_o = led1_q;
   assign bus.busy_o  = busy_q;
   assign bus.done_o  = done_q;

endmodule

// File: tb/tb_build_id_blinker.sv
// Self-checking bench for build_id_blinker: per-cycle LED/busy trace from a queue-based
// model of the blink-out sequence, with abort, reset and ignored-start scenarios.
module tb_build_id_blinker;

   localparam int unsigned TD = 4;
   localparam int PH_MARK = 0;
   localparam int PH_SHOW = 1;
   localparam int PH_GAP  = 2;

   typedef struct {
      logic [2:0] l0;
      logic [2:0] l1;
      int         word;
      int         phase;
   } frame_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   frame_t exp_q[$];
   int checks = 0;
   int errors = 0;

   build_id_blinker_if bus();

   build_id_blinker #(.TICK_DIV(TD)) dut (
      .clk100 (clk),
      .rstn   (rstn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic randomize_inputs();
      bus.git_hash_scripts_i  = {$urandom, $urandom};
      bus.timestamp_scripts_i = $urandom;
      bus.git_hash_top_i      = {$urandom, $urandom};
      bus.timestamp_top_i     = $urandom;
      bus.git_hash_common_i   = {$urandom, $urandom};
      bus.timestamp_common_i  = $urandom;
      bus.led_0_i             = 3'($urandom_range(0, 7));
      bus.led_1_i             = 3'($urandom_range(0, 7));
   endtask

   // One frame per clock cycle: MARK 1 tick, then per nibble SHOW 2 ticks + GAP 1 tick
   task automatic build_model();
      logic [63:0] w [6];
      logic [3:0]  nib;
      int          nn;
      w[0] = bus.git_hash_scripts_i;
      w[1] = {32'd0, bus.timestamp_scripts_i};
      w[2] = bus.git_hash_top_i;
      w[3] = {32'd0, bus.timestamp_top_i};
      w[4] = bus.git_hash_common_i;
      w[5] = {32'd0, bus.timestamp_common_i};
      exp_q.delete();
      for (int wi = 0; wi < 6; wi++) begin
         nn = (wi % 2 == 0) ? 16 : 8;
         for (int c = 0; c < int'(TD); c++)
            exp_q.push_back('{l0: 3'b111, l1: 3'(wi + 1), word: wi + 1, phase: PH_MARK});
         for (int n = nn - 1; n >= 0; n--) begin
            nib = w[wi][n*4 +: 4];
            for (int c = 0; c < 2 * int'(TD); c++)
               exp_q.push_back('{l0: nib[2:0], l1: {2'b00, nib[3]}, word: wi + 1, phase: PH_SHOW});
            for (int c = 0; c < int'(TD); c++)
               exp_q.push_back('{l0: 3'b000, l1: 3'b000, word: wi + 1, phase: PH_GAP});
         end
      end
   endtask

   function automatic int pick(input int word, input int phase);
      int idx[$];
      for (int k = 0; k < exp_q.size(); k++)
         if (exp_q[k].word == word && exp_q[k].phase == phase) idx.push_back(k);
      return idx[$urandom_range(0, idx.size() - 1)];
   endfunction

   task automatic start_seq();
      build_model();
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_led0"}, bus.led_0_o, bus.led_0_i);
      chk({tag, "_led1"}, bus.led_1_o, bus.led_1_i);
      chk({tag, "_busy"}, bus.busy_o, 0);
   endtask

   // stop_kind: 1 = abort at frame stop_at, 2 = async reset at frame stop_at
   task automatic play(input int stop_at, input int stop_kind, input int change_at, input int restart_at);
      for (int k = 0; k < exp_q.size(); k++) begin
         chk($sformatf("led0@%0d", k), bus.led_0_o, exp_q[k].l0);
         chk($sformatf("led1@%0d", k), bus.led_1_o, exp_q[k].l1);
         chk($sformatf("busy@%0d", k), bus.busy_o, 1);
         chk($sformatf("done@%0d", k), bus.done_o, 0);
         if (k == stop_at && stop_kind == 1) begin
            bus.abort_i = 1'b1;
            step();
            bus.abort_i = 1'b0;
            chk_idle("abort");
            chk("abort_done", bus.done_o, 0);
            step();
            chk_idle("abort2");
            chk("abort2_done", bus.done_o, 0);
            return;
         end
         if (k == stop_at && stop_kind == 2) begin
            #2 rstn = 1'b0;
            #1;
            chk("rst_led0", bus.led_0_o, 0);
            chk("rst_led1", bus.led_1_o, 0);
            chk("rst_busy", bus.busy_o, 0);
            chk("rst_done", bus.done_o, 0);
            #3 rstn = 1'b1;
            step();
            chk_idle("rst_rel");
            chk("rst_rel_done", bus.done_o, 0);
            return;
         end
         if (k == change_at) randomize_inputs();
         bus.start_i = (k == restart_at);
         step();
      end
      bus.start_i = 1'b0;
      chk_idle("end");
      chk("end_done", bus.done_o, 1);
      step();
      chk_idle("post");
      chk("post_done", bus.done_o, 0);
   endtask

   initial begin
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      bus.git_hash_scripts_i  = '0;
      bus.timestamp_scripts_i = '0;
      bus.git_hash_top_i      = '0;
      bus.timestamp_top_i     = '0;
      bus.git_hash_common_i   = '0;
      bus.timestamp_common_i  = '0;
      bus.led_0_i = 3'b111;
      bus.led_1_i = 3'b111;

      // Reset holds every output low even with live pass-through inputs
      step();
      step();
      chk("init_led0", bus.led_0_o, 0);
      chk("init_led1", bus.led_1_o, 0);
      chk("init_busy", bus.busy_o, 0);
      chk("init_done", bus.done_o, 0);

      rstn = 1'b1;
      bus.led_0_i = 3'b101;
      bus.led_1_i = 3'b010;
      step();
      chk("pt_led0", bus.led_0_o, 3'b101);
      chk("pt_led1", bus.led_1_o, 3'b010);
      chk("pt_busy", bus.busy_o, 0);
      chk("pt_done", bus.done_o, 0);

      // Full sequence with the reference hash in word 1
      randomize_inputs();
      bus.git_hash_scripts_i = 64'h0123_4567_89AB_CDEF;
      step();
      start_seq();
      play(-1, 0, -1, -1);

      // Word ordering with inputs changed mid-sequence
      randomize_inputs();
      start_seq();
      play(-1, 0, pick(2, PH_SHOW), -1);

      // Abort during SHOW of word 3
      randomize_inputs();
      start_seq();
      play(pick(3, PH_SHOW), 1, -1, -1);

      // start and abort together in IDLE: no sequence
      bus.start_i = 1'b1;
      bus.abort_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      bus.abort_i = 1'b0;
      chk_idle("sa");
      chk("sa_done", bus.done_o, 0);
      step();
      chk_idle("sa2");

      // start pulsed while busy is ignored
      randomize_inputs();
      start_seq();
      play(-1, 0, -1, pick(1, PH_SHOW));

      // Reset during GAP, then a fresh full sequence
      randomize_inputs();
      start_seq();
      play(pick(4, PH_GAP), 2, -1, -1);
      randomize_inputs();
      step();
      start_seq();
      play(-1, 0, -1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/build_id_blinker.md
# build_id_blinker

Sequencer that owns the two 3-bit board LED groups and, on request, blinks out the six build-identification words (git hash and timestamp for scripts, top and common) nibble by nibble. When idle it passes the normal LED pattern (shift-register/counter display) through unchanged. It sits between the top-level LED logic and the `led_0`/`led_1` pins and is started by a software or button pulse.

## Interface
- `TICK_DIV`, default 25_000_000: clk100 cycles per display tick (250 ms at 100 MHz). Legal range is 2 or more.
- `clk100` in 1: system clock.
- `rstn` in 1: asynchronous active-low reset.
- `start_i` in 1: begin a blink-out sequence. Sampled only in IDLE.
- `abort_i` in 1: terminate the sequence immediately.
- `git_hash_scripts_i` in 64: word 1.
- `timestamp_scripts_i` in 32: word 2.
- `git_hash_top_i` in 64: word 3.
- `timestamp_top_i` in 32: word 4.
- `git_hash_common_i` in 64: word 5.
- `timestamp_common_i` in 32: word 6.
- `led_0_i` in 3: normal pattern for `led_0`, passed through when idle.
- `led_1_i` in 3: normal pattern for `led_1`, passed through when idle.
- `led_0_o` out 3: LED group 0 drive, registered.
- `led_1_o` out 3: LED group 1 drive, registered.
- `busy_o` out 1: high while a sequence is running, registered.
- `done_o` out 1: one-cycle pulse when a sequence completes normally, registered.

## Operation
- **States:** IDLE, MARK, SHOW, GAP.
- **Reset values:** state=IDLE; all outputs 0; word index, nibble index and prescaler are 0.
- **IDLE:**
  - `led_0_o` <= `led_0_i` and `led_1_o` <= `led_1_i`.
  - If `start_i`=1 and `abort_i`=0: capture all six words into shadow registers, set word=1, clear the prescaler, and go to MARK.
- **MARK (1 tick):**
  - `led_0_o`=3'b111 and `led_1_o`=word index (1..6).
  - On the tick, go to SHOW with nibble=most significant.
- **SHOW (2 ticks):**
  - `led_0_o`=nibble[2:0] and `led_1_o`={2'b00, nibble[3]}.
  - Nibbles are shown MSB first. 64-bit words have 16 nibbles; 32-bit words have 8.
- **GAP (1 tick):**
  - All LEDs off.
  - On the tick:
    - If nibbles remain: go to SHOW with the next nibble.
    - Else if word<6: go to MARK with word+1.
    - Else: go to IDLE and pulse `done_o`.
- **Prescaler:**
  - Counts 0..TICK_DIV-1 while not in IDLE.
  - A tick occurs on the cycle the count equals TICK_DIV-1; the count then wraps to 0.
  - The count is held at 0 in IDLE.
- **Shadow words:** input changes during a sequence have no effect; the displayed values are those captured at start.
- **`abort_i`:**
  - In any non-IDLE state, go to IDLE next cycle with `busy_o`=0 and `done_o`=0.
  - If `abort_i` and `start_i` are both high in IDLE, abort wins and no sequence starts.
- **`start_i` while busy:** ignored; no restart and no queuing.
- **`busy_o`:** 1 in every non-IDLE state.

## Timing
- Output latency:
  - State and LED outputs update on the same edge: start sampled at edge N gives MARK LEDs and `busy_o`=1 from N+1.
  - IDLE pass-through has 1 cycle of latency.
- Sequence length:
  - 64-bit word: 1 + 16×3 = 49 ticks.
  - 32-bit word: 1 + 8×3 = 25 ticks.
  - Total: 222 ticks = 222×TICK_DIV cycles of `busy_o`=1.
- `done_o` is high for exactly one cycle: the first cycle back in IDLE, the same cycle `busy_o` falls. LEDs resume pass-through on that cycle.
- Asynchronous reset mid-sequence immediately forces IDLE with all outputs 0. Pass-through resumes on the first edge after `rstn` deasserts.

## Test plan
- **Reset and pass-through:** with `rstn` low, all outputs are 0. After release, drive `led_0_i`=3'b101 and `led_1_i`=3'b010 → outputs follow one cycle later; `busy_o`=0.
- **Full sequence:** TICK_DIV=4, `git_hash_scripts_i`=64'h0123_4567_89AB_CDEF, `start_i` pulse →
  - MARK: `led_1_o`=3'b001 for 4 cycles.
  - First SHOW: `led_0_o`=000, `led_1_o`=000 for 8 cycles.
  - Then GAP.
  - Nibble 8: `led_0_o`=000, `led_1_o`=001.
  - Nibble F: `led_0_o`=111, `led_1_o`=001.
  - `busy_o` high for exactly 888 cycles, then `done_o` high for 1 cycle.
- **Word ordering:** distinct patterns on all six inputs → MARK shows `led_1_o`=1..6 in order and each word's nibbles match its input. Change the inputs mid-sequence → display unchanged.
- **Abort:** assert `abort_i` in SHOW of word 3 → IDLE next cycle, `busy_o`=0, no `done_o`, pass-through resumes.
- **Simultaneous and ignored starts:** `start_i`+`abort_i` together in IDLE → no start. `start_i` pulsed during SHOW → ignored; total length still 888 cycles.
- **Reset mid-sequence:** drop `rstn` during GAP → outputs 0 immediately. A new `start_i` after release → full sequence from word 1.
